// File: rtl/lms_fifo_reader_if.sv
// Read-side FIFO port plus the framed sample stream produced by lms_fifo_reader.
// master = the reader itself, slave = the FIFO/sink environment around it.
interface lms_fifo_reader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11
);
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_rd_empty;
    logic [DEPTH_WIDTH:0]   fifo_rd_water_level;
    logic                   m_valid;
    logic                   m_ready;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_first;
    logic                   m_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        input  fifo_rd_water_level,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_first,
        output m_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        output fifo_rd_water_level,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_first,
        input  m_last
    );
endinterface

// File: rtl/lms_fifo_reader.sv
// Pulls fixed-length LMS frames out of a read-latency-1 FIFO once enough samples are
// buffered and streams them through a 2-entry skid buffer with first/last markers.
module lms_fifo_reader_chk #(
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  in_burst,
    input logic                  rd_en,
    input logic                  rd_empty,
    input logic                  inflight,
    input logic                  tail_valid,
    input logic                  pop,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [DATA_WIDTH-1:0] m_data
);
    a_rd_legal: assert property (@(posedge clk) disable iff (!rst_n)
        rd_en |-> (in_burst && !rd_empty));

    // A capture into a full buffer with no drain would lose a word
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(tail_valid && inflight && !pop));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
endmodule

module lms_fifo_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11,
    parameter int FRAME_LEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    lms_fifo_reader_if.master bus,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       frame_cnt
);
    localparam int RCNT_W = $clog2(FRAME_LEN + 1);
    localparam int IDX_W  = $clog2(FRAME_LEN);

    localparam logic [RCNT_W-1:0]    RD_LOAD  = RCNT_W'(FRAME_LEN);
    localparam logic [RCNT_W-1:0]    RD_ONE   = RCNT_W'(1);
    localparam logic [RCNT_W-1:0]    RD_ZERO  = RCNT_W'(0);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_ZERO = IDX_W'(0);
    localparam logic [DEPTH_WIDTH:0] LVL_NEED = (DEPTH_WIDTH + 1)'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   load_s;
    logic                   rd_en_s;
    logic                   pop_s;
    logic                   last_hs_s;
    logic [1:0]             occ_eff_s;

    logic [RCNT_W-1:0]      rd_left_r;
    logic                   inflight_r;
    logic                   head_valid_r;
    logic                   tail_valid_r;
    logic [DATA_WIDTH-1:0]  head_data_r;
    logic [DATA_WIDTH-1:0]  tail_data_r;
    logic [IDX_W-1:0]       out_idx_r;
    logic                   underrun_r;
    logic [15:0]            frame_cnt_r;

    // Handshake decode and read permission. Occupancy counts the slot freed by this
    // cycle's handshake, otherwise back-to-back reads could not sustain one per cycle.
    always_comb begin
        pop_s     = head_valid_r & bus.m_ready;
        last_hs_s = pop_s & (out_idx_r == IDX_LAST);
        occ_eff_s = {1'b0, head_valid_r} + {1'b0, tail_valid_r}
                  + {1'b0, inflight_r} - {1'b0, pop_s};
        if ((state_r == ST_BURST) && (rd_left_r != RD_ZERO) &&
            !bus.fifo_rd_empty && (occ_eff_s < 2'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state logic; enable is only consulted outside BURST/FLUSH so frames never abort
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else if (bus.fifo_rd_water_level >= LVL_NEED) begin
                    state_s = ST_BURST;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_BURST: begin
                if (rd_en_s && (rd_left_r == RD_ONE)) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_FLUSH: begin
                if (last_hs_s) begin
                    if (enable) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Reads remaining in the frame and the one-deep read-latency tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_left_r  <= RD_ZERO;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if (load_s) begin
                rd_left_r <= RD_LOAD;
            end else if (rd_en_s) begin
                rd_left_r <= rd_left_r - RD_ONE;
            end else begin
                rd_left_r <= rd_left_r;
            end
        end
    end

    // Two-entry skid buffer: head drives the output, tail absorbs a word while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_r <= 1'b0;
            tail_valid_r <= 1'b0;
            head_data_r  <= {DATA_WIDTH{1'b0}};
            tail_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (!head_valid_r) begin
                        head_data_r  <= bus.fifo_rd_data;
                        head_valid_r <= 1'b1;
                    end else begin
                        tail_data_r  <= bus.fifo_rd_data;
                        tail_valid_r <= 1'b1;
                    end
                end
                2'b01: begin
                    if (tail_valid_r) begin
                        head_data_r  <= tail_data_r;
                        tail_valid_r <= 1'b0;
                    end else begin
                        head_valid_r <= 1'b0;
                    end
                end
                2'b11: begin
                    if (tail_valid_r) begin
                        head_data_r <= tail_data_r;
                        tail_data_r <= bus.fifo_rd_data;
                    end else begin
                        head_data_r <= bus.fifo_rd_data;
                    end
                end
                default: begin
                    head_valid_r <= head_valid_r;
                end
            endcase
        end
    end

    // Output sample index, completed-frame counter and sticky underrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r   <= IDX_ZERO;
            frame_cnt_r <= 16'd0;
            underrun_r  <= 1'b0;
        end else begin
            if (last_hs_s) begin
                out_idx_r   <= IDX_ZERO;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else if (pop_s) begin
                out_idx_r   <= out_idx_r + IDX_ONE;
                frame_cnt_r <= frame_cnt_r;
            end else begin
                out_idx_r   <= out_idx_r;
                frame_cnt_r <= frame_cnt_r;
            end
            if ((state_r == ST_BURST) && (rd_left_r != RD_ZERO) && bus.fifo_rd_empty) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = head_valid_r;
    assign bus.m_data     = head_data_r;
    assign bus.m_first    = head_valid_r & (out_idx_r == IDX_ZERO);
    assign bus.m_last     = head_valid_r & (out_idx_r == IDX_LAST);
    assign busy           = (state_r == ST_BURST) || (state_r == ST_FLUSH);
    assign underrun       = underrun_r;
    assign frame_cnt      = frame_cnt_r;

    lms_fifo_reader_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_burst   (state_r == ST_BURST),
        .rd_en      (rd_en_s),
        .rd_empty   (bus.fifo_rd_empty),
        .inflight   (inflight_r),
        .tail_valid (tail_valid_r),
        .pop        (pop_s),
        .m_valid    (head_valid_r),
        .m_ready    (bus.m_ready),
        .m_data     (head_data_r)
    );
endmodule

// File: tb/tb_lms_fifo_reader.sv
// Bench for lms_fifo_reader: behavioural latency-1 FIFO, expected-sample queue filled
// as words are written, scenario table for whole frames plus hand-written corner cases.
module tb_lms_fifo_reader;
    localparam int DW = 16;
    localparam int LW = 11;
    localparam int FL = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    lms_fifo_reader_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(LW)) bus ();

    lms_fifo_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(LW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } exp_t;

    typedef struct {
        int push;
        bit rnd_ready;
        int drop_at;
        int empty_at;
        bit chk_span;
        bit exp_underrun;
    } vec_t;

    exp_t          exp_q[$];
    exp_t          hold_e;
    logic [DW-1:0] mem [0:1023];
    int wr_ptr = 0, rd_ptr = 0, exp_idx = 0;
    int errors = 0, checks = 0;
    int occ = 0, inflight = 0, hs_total = 0, exp_frames = 0, cyc = 0;
    int reads_in_frame = 0, out_in_frame = 0, rd_first_cyc = 0, rd_last_cyc = 0;
    int drop_at = -1, empty_at = -1, force_cnt = 0;
    bit rnd_ready = 1'b0, hold_pend = 1'b0, drop_pend = 1'b0, empty_trig = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_exp(input logic [DW-1:0] d);
        exp_t e;
        e.data  = d;
        e.first = (exp_idx == 0);
        e.last  = (exp_idx == FL - 1);
        exp_q.push_back(e);
        exp_idx = (exp_idx + 1) % FL;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = DW'($urandom);
            add_exp(mem[wr_ptr]);
            wr_ptr++;
        end
    endtask

    task automatic apply_inputs();
        int lvl;
        lvl = wr_ptr - rd_ptr;
        bus.fifo_rd_water_level = (LW + 1)'(lvl);
        bus.fifo_rd_empty       = (lvl == 0) || (force_cnt > 0);
        bus.m_ready             = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: sample/compare at the falling edge, update model and drive after the rising edge
    task automatic cycle(output logic rd_o);
        logic rd, hs;
        exp_t e, got;
        @(negedge clk);
        rd  = bus.fifo_rd_en;
        hs  = bus.m_valid & bus.m_ready;
        got = {bus.m_data, bus.m_first, bus.m_last};
        check("valid_vs_occupancy", bus.m_valid, (occ != 0));
        check("occupancy_le_2", (occ <= 2), 1);
        check("rd_when_empty", rd & bus.fifo_rd_empty, 0);
        check("frame_cnt", frame_cnt, exp_frames);
        if (hold_pend) check("hold_stable", {bus.m_valid, got}, {1'b1, hold_e});
        hold_pend = bus.m_valid & !bus.m_ready;
        hold_e    = got;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sample", got, e);
                if (e.last) exp_frames++;
            end
            hs_total++;
            out_in_frame++;
            if (drop_at >= 0 && out_in_frame == drop_at + 1) drop_pend = 1'b1;
        end
        if (rd) begin
            reads_in_frame++;
            if (reads_in_frame == 1) rd_first_cyc = cyc;
            rd_last_cyc = cyc;
            if (reads_in_frame == empty_at) empty_trig = 1'b1;
        end
        @(posedge clk);
        #1;
        occ      = occ + inflight - int'(hs);
        inflight = int'(rd);
        if (rd) begin
            bus.fifo_rd_data = mem[rd_ptr];
            rd_ptr++;
        end else begin
            bus.fifo_rd_data = DW'($urandom);
        end
        cyc++;
        if (force_cnt > 0) force_cnt--;
        if (empty_trig) begin
            force_cnt  = 5;
            empty_trig = 1'b0;
        end
        if (drop_pend) begin
            enable    = 1'b0;
            drop_pend = 1'b0;
        end
        apply_inputs();
        rd_o = rd;
    endtask

    task automatic run_frame();
        int   target;
        logic rd;
        target         = hs_total + FL;
        reads_in_frame = 0;
        out_in_frame   = 0;
        for (int i = 0; i < 600 && hs_total < target; i++) cycle(rd);
        check("frame_done", (hs_total >= target), 1);
    endtask

    vec_t vecs[4];
    vec_t cur;
    logic rd;
    int   rd_sum;

    initial begin
        vecs[0] = '{push: 40, rnd_ready: 1'b0, drop_at: -1, empty_at: -1, chk_span: 1'b1, exp_underrun: 1'b0};
        vecs[1] = '{push: 32, rnd_ready: 1'b1, drop_at: -1, empty_at: -1, chk_span: 1'b0, exp_underrun: 1'b0};
        vecs[2] = '{push: 32, rnd_ready: 1'b0, drop_at: -1, empty_at: 10, chk_span: 1'b0, exp_underrun: 1'b1};
        vecs[3] = '{push: 32, rnd_ready: 1'b0, drop_at: 5,  empty_at: -1, chk_span: 1'b0, exp_underrun: 1'b1};

        rst_n  = 1'b0;
        enable = 1'b0;
        bus.fifo_rd_data = '0;
        apply_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_first_last", {bus.m_first, bus.m_last}, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;

        // Whole-frame scenarios
        for (int v = 0; v < 4; v++) begin
            cur       = vecs[v];
            rnd_ready = cur.rnd_ready;
            drop_at   = cur.drop_at;
            empty_at  = cur.empty_at;
            enable    = 1'b1;
            push_words(cur.push);
            apply_inputs();
            run_frame();
            repeat (4) cycle(rd);
            check("underrun_after", underrun, cur.exp_underrun);
            check("busy_after", busy, 0);
            if (cur.chk_span) begin
                check("read_span", rd_last_cyc - rd_first_cyc + 1, FL);
                check("read_count", reads_in_frame, FL);
            end
        end
        rnd_ready = 1'b0;
        drop_at   = -1;
        empty_at  = -1;

        // Enable low after the dropped frame: plenty of data but no new frame
        push_words(32);
        apply_inputs();
        rd_sum = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(rd);
            rd_sum += int'(rd);
        end
        check("idle_no_reads", rd_sum, 0);
        check("idle_busy", busy, 0);
        enable = 1'b1;
        apply_inputs();
        run_frame();

        // Level one short of a frame holds in WAIT; reaching FRAME_LEN starts the burst next cycle
        repeat (4) cycle(rd);
        push_words(23);
        apply_inputs();
        rd_sum = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(rd);
            rd_sum += int'(rd);
        end
        check("wait_no_reads", rd_sum, 0);
        check("wait_busy", busy, 0);
        push_words(1);
        apply_inputs();
        cycle(rd);
        check("wait_sees_level", rd, 0);
        cycle(rd);
        check("burst_next_cycle", rd, 1);
        check("burst_busy", busy, 1);
        run_frame();
        repeat (3) cycle(rd);

        // Reset in mid-frame after 12 samples have left
        push_words(40);
        apply_inputs();
        begin
            int target;
            target = hs_total + 12;
            for (int i = 0; i < 200 && hs_total < target; i++) cycle(rd);
            check("reached_sample_12", (hs_total >= target), 1);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", bus.fifo_rd_en, 0);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_m_data", bus.m_data, 0);
        check("mid_rst_first_last", {bus.m_first, bus.m_last}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        exp_idx    = 0;
        occ        = 0;
        inflight   = 0;
        hold_pend  = 1'b0;
        exp_frames = 0;
        for (int p = rd_ptr; p < wr_ptr; p++) add_exp(mem[p]);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_words(32);
        apply_inputs();
        run_frame();
        repeat (3) cycle(rd);
        check("post_rst_frame_cnt", frame_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lms_fifo_reader.md
LMS_FIFO_READER -- requirements
Module: lms_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width matching the FIFO read data.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 11, FIFO read water level width minus one.
REQ-003 SHALL have parameter FRAME_LEN, default 32, samples per LMS frame (range 2..2^DEPTH_WIDTH).
REQ-004 Port list (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permit new frames to start
- fifo_rd_en  out  1  FIFO read enable
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty flag
- fifo_rd_water_level  in  DEPTH_WIDTH+1  FIFO read-side fill level
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  output sample
- m_first  out  1  current m_data is sample 0 of a frame
- m_last  out  1  current m_data is sample FRAME_LEN-1
- busy  out  1  state not IDLE/WAIT
- underrun  out  1  sticky underrun flag
- frame_cnt  out  16  frames completed, wraps at 65535->0

Function
REQ-005 SHALL implement states IDLE, WAIT, BURST, FLUSH.
REQ-006 IDLE: enable=1 -> WAIT; else stay.
REQ-007 WAIT: enable=0 -> IDLE; fifo_rd_water_level >= FRAME_LEN -> BURST (next cycle); else stay.
REQ-008 BURST: issue exactly FRAME_LEN reads; after last read issued -> FLUSH.
REQ-009 FLUSH: when output handshake of m_last completes (m_valid & m_ready & m_last) -> WAIT if enable=1, else IDLE.
REQ-010 enable deasserted during BURST/FLUSH SHALL NOT abort; current frame completes.
REQ-011 fifo_rd_en SHALL be asserted only in BURST, with reads remaining > 0, fifo_rd_empty=0, and (buffer occupancy + reads in flight) < 2.
REQ-012 Read latency: data from fifo_rd_en in cycle N SHALL be captured into the skid buffer at end of cycle N+1.
REQ-013 Skid buffer: 2 entries, FIFO order; never overflows; captured words SHALL never be dropped or duplicated.
REQ-014 m_valid=1 whenever buffer non-empty; m_data/m_first/m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-015 With m_ready held 1 and FIFO non-empty, SHALL sustain one sample per cycle after 2-cycle start-up (WAIT->BURST cycle, then read latency).
REQ-016 Output sample index counter 0..FRAME_LEN-1 increments on each handshake, wraps to 0 after m_last handshake; m_first=(index==0), m_last=(index==FRAME_LEN-1).
REQ-017 frame_cnt SHALL increment by 1 on each m_last handshake.
REQ-018 Underrun: in BURST with reads remaining > 0 and fifo_rd_empty=1, SHALL suppress fifo_rd_en, set underrun=1 (sticky until reset), and resume reading when empty clears.
REQ-019 Simultaneous capture and output handshake in one cycle SHALL keep occupancy unchanged.
REQ-020 Read counter SHALL be ceil(log2(FRAME_LEN+1)) bits; no wrap within a frame.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE, fifo_rd_en=0, m_valid=0, m_data=0, m_first=0, m_last=0, busy=0, underrun=0, frame_cnt=0, buffer empty, all counters 0.
REQ-022 Reset asserted mid-frame SHALL discard buffered and in-flight samples; after release, first m_valid sample SHALL carry m_first=1.

Verification
REQ-023 FRAME_LEN=32, level=40, enable=1, m_ready=1 -> 32 reads in 32 consecutive cycles, samples 0..31 out in order, m_first on #0, m_last on #31, frame_cnt=1.
REQ-024 level=31 held, enable=1 -> stays WAIT, fifo_rd_en never asserted; raise level to 32 -> BURST next cycle.
REQ-025 m_ready toggled randomly 50% during a frame -> no loss/duplication, payload matches FIFO order, occupancy never exceeds 2.
REQ-026 fifo_rd_empty forced 1 for 5 cycles after read 10 -> no fifo_rd_en those cycles, underrun=1, frame completes with 32 correct samples.
REQ-027 enable dropped at sample 5 -> frame finishes (m_last at #31), then state IDLE, busy=0.
REQ-028 rst_n pulsed low at sample 12 -> all outputs 0 in same cycle; after release and level>=32, next output sample has m_first=1, frame_cnt=0.
